register_file_mp: RTL and testbench
===================================

# register_file_mp

Parametrised multi-read-port register file for the RISC-V core; the successor of the fixed 32×32, two-read/one-write register file. It adds configurable width, depth and read-port count, a hardwired zero register, optional write-to-read bypass, and a self-clearing sequencer. The sequencer zeroes the array after reset or on request, so the datapath never reads uninitialised state. It sits between decode (read addresses) and writeback (write port).

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, register count; power of two, ≥ 2
- NRD, 2, number of combinational read ports, ≥ 1
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- we  in  1  write enable
- wa  in  AW  write address, AW = log2(NREGS)
- wd  in  XLEN  write data
- ra  in  NRD*AW  packed read addresses; port i at bits [i*AW +: AW]
- rd  out  NRD*XLEN  packed read data; port i at bits [i*XLEN +: XLEN]
- clr_req  in  1  start a full-array clear (one-cycle pulse or level)
- clr_busy  out  1  clear in progress; writes are ignored

## Operation
- Writes: on the rising edge with we=1, clr_busy=0 and not (ZERO_REG and wa==0), the array stores mem[wa] ← wd.
- Reads: combinational. rd[i] = 0 if clr_busy=1, or if ZERO_REG and ra[i]==0. Otherwise rd[i] = mem[ra[i]], with the bypass below applied.
- All read ports are independent. Any number of them may carry the same address.
- Clear FSM, states IDLE and CLEAR:
  - IDLE → CLEAR on clr_req=1. The index counter loads 0.
  - In CLEAR: each cycle mem[idx] ← 0, then idx increments.
  - When idx==NREGS-1 and that location has been written, the FSM returns to IDLE.
  - clr_busy = (state==CLEAR).
- Reset: asserting rst_n forces state=CLEAR and idx=0. The array itself has no reset; it is zeroed by the sequencer.
- Boundary conditions:
  - clr_req while in CLEAR: ignored; the sequence is not restarted.
  - clr_req and we both high in IDLE: clear wins and the write is dropped.
  - we=1 during CLEAR: dropped silently.
  - rst_n asserted mid-clear: the sequence restarts from idx 0.
  - idx is AW bits wide; it never wraps past NREGS-1.

## Timing
- Read latency 0 cycles (combinational from ra and array state).
- Write latency: the value is visible on rd in the cycle after the write edge. With bypass compiled in, it is visible in the same cycle.
- Clear duration: exactly NREGS cycles from the first CLEAR edge. clr_busy is high for NREGS cycles, and the next write is accepted on the edge after clr_busy falls.
- Output values while rst_n is low and after its release: clr_busy=1 and all rd=0, lasting until the clear completes.

## Configuration
- Macro REGFILE_BYPASS_EN.
- Defined: when clr_busy=0, we=1, ra[i]==wa and not (ZERO_REG and wa==0), then rd[i]=wd in the same cycle (write-through forwarding).
- Undefined: rd[i] shows the old mem content until the next edge. The pipeline must handle the hazard.
- The macro does not affect the clear or zero-register rules.

## Structure
- Package regfile_pkg holds:
  - the clear-state enum (CLR_IDLE, CLR_RUN)
  - a clog2-based address-width helper
  - default XLEN/NREGS constants shared with decode and writeback
- Sub-module regfile_clear_seq: the FSM plus index counter. Outputs clr_busy, clr_we and clr_addr; the top muxes these onto the write port.
- The top holds the array, the write mux and a generate loop over the NRD read ports.

## Test plan
- Reset release: hold rst_n low 3 cycles, then release → clr_busy=1 for exactly 32 cycles, all rd=0, then clr_busy=0 and all registers read 0.
- Write/read: write wa=9, wd=10; next cycle ra0=9, ra1=9 → rd0=rd1=10. Write wa=0, wd=0xFFFFFFFF → rd for ra=0 stays 0.
- Bypass: in the same cycle drive we=1, wa=5, wd=0x1234, ra0=5 → rd0=0x1234 with REGFILE_BYPASS_EN defined; rd0=previous value (0) without it.
- Clear request: fill x1..x31 with 1..31, then pulse clr_req → 32 busy cycles, a write issued mid-clear is dropped, and all registers then read 0.
- Collision and mid-clear reset: clr_req with we=1 (wa=3, wd=7) → x3 reads 0 after the clear. Asserting rst_n at clear cycle 10 → busy lasts a further 32 cycles from the reset release.
- Parameter sweep: XLEN=64, NREGS=16, NRD=3, ZERO_REG=0 → x0 is writable, all three ports read correctly, and the clear takes 16 cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file definitions: clear-sequencer states, address-width helper
// and the default geometry that decode and writeback size their ports from.
package regfile_pkg;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_e;

  localparam int unsigned RF_XLEN  = 32;
  localparam int unsigned RF_NREGS = 32;
  localparam int unsigned RF_NRD   = 2;

  // Address bits needed to index n registers (at least one bit).
  function automatic int unsigned rf_addr_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks every register index and zeroes it after reset or on clr_req.
// Latency: busy for exactly NREGS cycles from the edge that starts the clear.
// Backpressure: clr_req while busy is ignored; clr_busy_o tells the top to drop user writes.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter  int unsigned NREGS = RF_NREGS,
  localparam int unsigned AW    = rf_addr_w(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req_i,
  output logic          clr_busy_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o
);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  // State and index registers; reset starts a clear from index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR_RUN;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: start on request, step the index, stop after the last location.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      CLR_IDLE: begin
        if (clr_req_i) begin
          state_d = CLR_RUN;
          idx_d   = '0;
        end
      end
      CLR_RUN: begin
        // The last index is written this cycle; hold idx so it never wraps.
        if (idx_q == AW'(NREGS - 1)) begin
          state_d = CLR_IDLE;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  assign clr_busy_o = (state_q == CLR_RUN);
  assign clr_we_o   = (state_q == CLR_RUN);
  assign clr_addr_o = idx_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with optional hardwired x0 and self-clearing array.
// Latency: reads combinational; writes visible next cycle (same cycle with REGFILE_BYPASS_EN).
// Backpressure: writes are dropped while clr_busy is high or when clr_req is accepted.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN     = RF_XLEN,
  parameter  int unsigned NREGS    = RF_NREGS,
  parameter  int unsigned NRD      = RF_NRD,
  parameter  int unsigned ZERO_REG = 1,
  localparam int unsigned AW       = rf_addr_w(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  input  logic                clr_req,
  output logic                clr_busy
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [XLEN-1:0] mem_q [NREGS];

  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic            wa_ok;
  logic            usr_we;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_dat;

  regfile_clear_seq #(
    .NREGS (NREGS)
  ) u_clear_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_req_i  (clr_req),
    .clr_busy_o (clr_busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  // x0 is read-only when the zero register is hardwired.
  assign wa_ok  = !(ZR && (wa == '0));
  // A clear request accepted in idle wins over a simultaneous write.
  assign usr_we = we && !clr_busy && !clr_req && wa_ok;

  // Write-port mux: the sequencer owns the port while clearing.
  always_comb begin
    wr_en   = usr_we;
    wr_addr = wa;
    wr_dat  = wd;
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_dat  = '0;
    end
  end

  // Storage array: no reset, contents come from the clear sequencer.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_dat;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]   ra_sel;
    logic [XLEN-1:0] rd_val;

    assign ra_sel = ra[g*AW +: AW];

    // Read mux: clearing and the zero register override array and forwarding.
    always_comb begin
      rd_val = mem_q[ra_sel];
`ifdef REGFILE_BYPASS_EN
      if (!clr_busy && we && wa_ok && (ra_sel == wa)) begin
        rd_val = wd;
      end
`endif
      if (clr_busy || (ZR && (ra_sel == '0))) begin
        rd_val = '0;
      end
    end

    assign rd[g*XLEN +: XLEN] = rd_val;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a default 32x32/2-port/x0-zero instance and a
// 16x64/3-port/x0-writable instance share one stimulus stream and are both
// compared every cycle against an array-based model of the register file.
module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  wa;
  logic [63:0] wd;
  logic        clr_req;
  logic [4:0]  ra_t [3];
  logic [9:0]  ra_a;
  logic [11:0] ra_b;
  logic [63:0]  rd_a;
  logic [191:0] rd_b;
  logic        clr_busy_a, clr_busy_b;
  logic [31:0] rd_a32_0, rd_a32_1;

  int vectors = 0;
  int mism    = 0;
  bit check_en = 1'b0;

  // Model state: instance 0 = default build, instance 1 = parameter sweep.
  int          NR   [2] = '{32, 16};
  bit          ZRM  [2] = '{1'b1, 1'b0};
  logic [63:0] MASK [2] = '{64'h0000_0000_FFFF_FFFF, {64{1'b1}}};
  logic [63:0] mm   [2][32];
  int          busy [2] = '{0, 0};

  always #5 clk = ~clk;

  assign ra_a = {ra_t[1], ra_t[0]};
  assign ra_b = {ra_t[2][3:0], ra_t[1][3:0], ra_t[0][3:0]};
  assign rd_a[63:32] = '0;

  register_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1)) u_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .wa       (wa),
    .wd       (wd[31:0]),
    .ra       (ra_a),
    .rd       ({rd_a32_1, rd_a32_0}),
    .clr_req  (clr_req),
    .clr_busy (clr_busy_a)
  );

  assign rd_a[31:0] = rd_a32_0;

  register_file_mp #(.XLEN(64), .NREGS(16), .NRD(3), .ZERO_REG(0)) u_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .wa       (wa[3:0]),
    .wd       (wd),
    .ra       (ra_b),
    .rd       (rd_b),
    .clr_req  (clr_req),
    .clr_busy (clr_busy_b)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_rd(input int k, input int p);
    int a;
    logic [63:0] r;
    a = int'(ra_t[p]) % NR[k];
    if (busy[k] > 0) return 64'd0;
    if (ZRM[k] && a == 0) return 64'd0;
    r = mm[k][a];
`ifdef REGFILE_BYPASS_EN
    if (we && a == (int'(wa) % NR[k]) && !(ZRM[k] && (int'(wa) % NR[k]) == 0))
      r = wd & MASK[k];
`endif
    return r;
  endfunction

  // Model: a clear (reset or request) zeroes everything at once and then counts
  // NREGS busy cycles; writes land only when not busy.
  initial begin
    int w;
    forever begin
      @(posedge clk or negedge rst_n);
      for (int k = 0; k < 2; k++) begin
        w = int'(wa) % NR[k];
        if (!rst_n || (busy[k] == 0 && clr_req)) begin
          busy[k] = NR[k];
          for (int i = 0; i < 32; i++) mm[k][i] = 64'd0;
        end else if (busy[k] > 0) begin
          busy[k]--;
        end else if (we && !(ZRM[k] && w == 0)) begin
          mm[k][w] = wd & MASK[k];
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        chk("busy_a", 64'(clr_busy_a), 64'(busy[0] > 0));
        chk("busy_b", 64'(clr_busy_b), 64'(busy[1] > 0));
        chk("rd_a0", 64'(rd_a32_0), exp_rd(0, 0));
        chk("rd_a1", 64'(rd_a32_1), exp_rd(0, 1));
        for (int p = 0; p < 3; p++)
          chk($sformatf("rd_b%0d", p), rd_b[p*64 +: 64], exp_rd(1, p));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until each instance's clr_busy falls (busy must be high on entry).
  task automatic run_busy(input int wr_at, output int na, output int nb);
    na = 0;
    nb = 0;
    for (int n = 1; n <= 100; n++) begin
      we = (n == wr_at);
      wa = 5'd7;
      wd = 64'd99;
      tick();
      if (!clr_busy_b && nb == 0) nb = n;
      if (!clr_busy_a) begin
        na = n;
        break;
      end
    end
    we = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int na, nb;
    rst_n = 1'b1; we = 1'b0; wa = '0; wd = '0; clr_req = 1'b0;
    for (int j = 0; j < 3; j++) ra_t[j] = '0;
    #2 rst_n = 1'b0;
    #1 check_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run_busy(-1, na, nb);
    chk("rst_len_a", 64'(na), 64'd32);
    chk("rst_len_b", 64'(nb), 64'd16);

    ra_t[0] = 5'd17; ra_t[1] = 5'd4; ra_t[2] = 5'd12;
    @(negedge clk);
    chk("post_rst_a0", 64'(rd_a32_0), 64'd0);
    chk("post_rst_b2", rd_b[191:128], 64'd0);
    tick();

    // Plain write then read on every port.
    we = 1'b1; wa = 5'd9; wd = 64'd10;
    for (int j = 0; j < 3; j++) ra_t[j] = 5'd9;
    tick();
    we = 1'b0;
    @(negedge clk);
    chk("wr9_a0", 64'(rd_a32_0), 64'd10);
    chk("wr9_a1", 64'(rd_a32_1), 64'd10);
    chk("wr9_b2", rd_b[191:128], 64'd10);
    tick();

    // x0: hardwired zero in the default build, writable in the sweep build.
    we = 1'b1; wa = 5'd0; wd = 64'h0000_0000_FFFF_FFFF;
    tick();
    we = 1'b0; ra_t[0] = 5'd0;
    @(negedge clk);
    chk("x0_a0", 64'(rd_a32_0), 64'd0);
    chk("x0_b0", rd_b[63:0], 64'h0000_0000_FFFF_FFFF);
    tick();

    // Same-cycle read of the register being written.
    we = 1'b1; wa = 5'd5; wd = 64'h1234; ra_t[0] = 5'd5;
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    chk("byp_a0", 64'(rd_a32_0), 64'h1234);
`else
    chk("byp_a0", 64'(rd_a32_0), 64'd0);
`endif
    tick();
    we = 1'b0;

    // Fill x1..x31 with their own index.
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wa = 5'(i); wd = 64'(i);
      tick();
    end
    we = 1'b0;
    ra_t[0] = 5'd31; ra_t[1] = 5'd20; ra_t[2] = 5'd3;
    @(negedge clk);
    chk("fill_a0", 64'(rd_a32_0), 64'd31);
    chk("fill_a1", 64'(rd_a32_1), 64'd20);
    chk("fill_b2", rd_b[191:128], 64'd19);
    tick();

    // Requested clear with a write issued mid-clear.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    run_busy(10, na, nb);
    chk("clr_len_a", 64'(na), 64'd32);
    chk("clr_len_b", 64'(nb), 64'd16);
    ra_t[0] = 5'd7; ra_t[1] = 5'd1; ra_t[2] = 5'd31;
    @(negedge clk);
    chk("clr_a0", 64'(rd_a32_0), 64'd0);
    chk("clr_a1", 64'(rd_a32_1), 64'd0);
    chk("clr_b0", rd_b[63:0], 64'd0);
    tick();

    // Clear request and write together: the write is dropped.
    clr_req = 1'b1; we = 1'b1; wa = 5'd3; wd = 64'd7;
    tick();
    clr_req = 1'b0; we = 1'b0;
    run_busy(-1, na, nb);
    chk("col_len_a", 64'(na), 64'd32);
    ra_t[0] = 5'd3; ra_t[2] = 5'd3;
    @(negedge clk);
    chk("col_a0", 64'(rd_a32_0), 64'd0);
    chk("col_b2", rd_b[191:128], 64'd0);
    tick();

    // Reset at clear cycle 10 restarts the whole sequence.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    run_busy(-1, na, nb);
    chk("mrst_len_a", 64'(na), 64'd32);
    chk("mrst_len_b", 64'(nb), 64'd16);

    // Randomised traffic with occasional clears and resets.
    for (int c = 0; c < 3000; c++) begin
      we      = 1'($urandom);
      wa      = 5'($urandom);
      wd      = {$urandom, $urandom};
      for (int j = 0; j < 3; j++) ra_t[j] = 5'($urandom);
      clr_req = ($urandom_range(0, 79) == 0);
      rst_n   = ($urandom_range(0, 599) != 0);
      tick();
    end
    rst_n = 1'b1; clr_req = 1'b0; we = 1'b0;
    tick();
    check_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, mism);
    $finish;
  end

endmodule
